// File: rtl/multi_buf_pkg.sv
// Shared types and helpers for the N-buffer frame arbiter: qualifier states,
// reset indices and the free-buffer scan used when the producer advances.
package multi_buf_pkg;

  typedef enum logic [1:0] {
    FIRST_WAIT  = 2'd0,
    SWITCH      = 2'd1,
    SECOND_WAIT = 2'd2
  } qual_state_t;

  localparam int WR_RST = 0;
  localparam int RD_RST = 1;

  // First index scanning (cur+1) mod n upward that avoids excl_a and, when valid, excl_b.
  function automatic int next_free(input int cur, input int excl_a, input int excl_b,
                                   input logic excl_b_vld, input int n);
    int   cand;
    logic found;
    found     = 1'b0;
    next_free = cur;
    for (int k = 1; k <= 8; k++) begin
      cand = (cur + k) % n;
      if (!found && k <= n && cand != excl_a && !(excl_b_vld && cand == excl_b)) begin
        next_free = cand;
        found     = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/multi_buf_control_trig_qual.sv
// Trigger qualifier: requires WAIT_CYCLES+1 consecutive active samples, emits a
// single-cycle sw request, then waits for the trigger to go inactive again.
module trig_qual
  import multi_buf_pkg::*;
#(
  parameter bit ACTIVE      = 1'b1,
  parameter int WAIT_CYCLES = 0,
  parameter int CNT_W       = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic trig,
  output logic sw
);

  qual_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             active;

  assign active = (trig == ACTIVE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= FIRST_WAIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sw         = 1'b0;
    case (state_reg)
      FIRST_WAIT: begin
        if (active) begin
          if (int'(cnt_reg) >= WAIT_CYCLES) begin
            cnt_next   = '0;
            state_next = SWITCH;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end else begin
          cnt_next = '0;
        end
      end
      SWITCH: begin
        sw         = 1'b1;
        state_next = SECOND_WAIT;
      end
      SECOND_WAIT: begin
        if (!active) state_next = FIRST_WAIT;
      end
      default: state_next = FIRST_WAIT;
    endcase
  end

endmodule

// File: rtl/multi_buf_control.sv
// N-buffer frame arbiter with drop detection, stale tracking and sticky error.
// Optional macro SEL_BLANK_HOLD_EN: selects only reload while a trigger is active.
module multi_buf_control
  import multi_buf_pkg::*;
#(
  parameter int  NUM_BUFS     = 3,
  parameter int  WAIT_CYCLES  = 0,
  parameter int  CNT_W        = 6,
  parameter bit  CAP_ACTIVE   = 1'b1,
  parameter bit  TRANS_ACTIVE = 1'b0,
  parameter int  MAX_REPEAT   = 2,
  localparam int BUF_W        = $clog2(NUM_BUFS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture_trigger,
  input  logic             transmission_trigger,
  output logic [BUF_W-1:0] wr_sel,
  output logic [BUF_W-1:0] rd_sel,
  output logic             wr_switch,
  output logic             rd_switch,
  output logic             frame_drop,
  output logic             stale,
  output logic             error
);

  localparam int REP_W = $clog2(MAX_REPEAT + 2);

  logic             cap_sw, trans_sw, sel_load, violation;
  logic [BUF_W-1:0] wr_reg, wr_next, rd_reg, rd_next, latest_reg, latest_next;
  logic [BUF_W-1:0] wr_sel_reg, rd_sel_reg;
  logic             latest_vld_reg, latest_vld_next;
  logic [REP_W-1:0] rep_reg, rep_next;
  logic             wr_switch_reg, rd_switch_reg, frame_drop_reg, stale_reg, error_reg;
  logic             rd_switch_next, frame_drop_next;

  trig_qual #(.ACTIVE(CAP_ACTIVE), .WAIT_CYCLES(WAIT_CYCLES), .CNT_W(CNT_W)) u_cap_qual (
    .clk(clk), .reset(reset), .trig(capture_trigger), .sw(cap_sw)
  );

  trig_qual #(.ACTIVE(TRANS_ACTIVE), .WAIT_CYCLES(WAIT_CYCLES), .CNT_W(CNT_W)) u_trans_qual (
    .clk(clk), .reset(reset), .trig(transmission_trigger), .sw(trans_sw)
  );

  // Producer is resolved first so a simultaneous consumer takes the just-finished frame.
  always_comb begin
    latest_next     = latest_reg;
    latest_vld_next = latest_vld_reg;
    frame_drop_next = 1'b0;
    rd_next         = rd_reg;
    rep_next        = rep_reg;
    rd_switch_next  = 1'b0;
    wr_next         = wr_reg;
    if (cap_sw) begin
      latest_next     = wr_reg;
      latest_vld_next = 1'b1;
      frame_drop_next = latest_vld_reg;
    end
    if (trans_sw) begin
      if (latest_vld_next) begin
        rd_next         = latest_next;
        latest_vld_next = 1'b0;
        rep_next        = '0;
        rd_switch_next  = 1'b1;
      end else if (int'(rep_reg) < MAX_REPEAT) begin
        rep_next = rep_reg + REP_W'(1);
      end
    end
    if (cap_sw) begin
      wr_next = BUF_W'(next_free(int'(wr_reg), int'(rd_next), int'(latest_next),
                                 latest_vld_next, NUM_BUFS));
    end
  end

  assign violation = (wr_reg == rd_reg)
                   || (latest_vld_reg && latest_reg == wr_reg)
                   || (int'(wr_reg) >= NUM_BUFS)
                   || (int'(rd_reg) >= NUM_BUFS)
                   || (int'(latest_reg) >= NUM_BUFS);

`ifdef SEL_BLANK_HOLD_EN
  assign sel_load = (capture_trigger == CAP_ACTIVE) || (transmission_trigger == TRANS_ACTIVE);
`else
  assign sel_load = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_reg         <= BUF_W'(WR_RST);
      rd_reg         <= BUF_W'(RD_RST);
      latest_reg     <= '0;
      latest_vld_reg <= 1'b0;
      rep_reg        <= '0;
      wr_sel_reg     <= BUF_W'(WR_RST);
      rd_sel_reg     <= BUF_W'(RD_RST);
      wr_switch_reg  <= 1'b0;
      rd_switch_reg  <= 1'b0;
      frame_drop_reg <= 1'b0;
      stale_reg      <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      wr_reg         <= wr_next;
      rd_reg         <= rd_next;
      latest_reg     <= latest_next;
      latest_vld_reg <= latest_vld_next;
      rep_reg        <= rep_next;
      wr_switch_reg  <= cap_sw;
      rd_switch_reg  <= rd_switch_next;
      frame_drop_reg <= frame_drop_next;
      stale_reg      <= (int'(rep_next) >= MAX_REPEAT);
      error_reg      <= error_reg | violation;
      if (sel_load) begin
        wr_sel_reg <= wr_reg;
        rd_sel_reg <= rd_reg;
      end
    end
  end

  assign wr_sel     = wr_sel_reg;
  assign rd_sel     = rd_sel_reg;
  assign wr_switch  = wr_switch_reg;
  assign rd_switch  = rd_switch_reg;
  assign frame_drop = frame_drop_reg;
  assign stale      = stale_reg;
  assign error      = error_reg;

endmodule

// File: tb/tb_multi_buf_control.sv
// Scoreboard bench for multi_buf_control: driver queues expected pulse counts and
// selector values, a negedge monitor accumulates pulses and compares on request.
module tb_multi_buf_control;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       capture_trigger = 1'b0;
  logic       transmission_trigger = 1'b1;
  logic [1:0] wr_sel, rd_sel;
  logic       wr_switch, rd_switch, frame_drop, stale, error;

  logic       cap_b = 1'b0;
  logic       trans_b = 1'b1;
  logic [1:0] wr_sel_b, rd_sel_b;
  logic       wr_switch_b, rd_switch_b, frame_drop_b, stale_b, error_b;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cnt  = 0;
  int done_cnt = 0;
  int acc_wr = 0, acc_rd = 0, acc_drop = 0;

  typedef struct {
    string name;
    int    nw, nr, nd, ws, rs, st;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  multi_buf_control #(.NUM_BUFS(3), .WAIT_CYCLES(0), .MAX_REPEAT(2)) dut (
    .clk(clk), .reset(reset), .capture_trigger(capture_trigger),
    .transmission_trigger(transmission_trigger), .wr_sel(wr_sel), .rd_sel(rd_sel),
    .wr_switch(wr_switch), .rd_switch(rd_switch), .frame_drop(frame_drop),
    .stale(stale), .error(error)
  );

  multi_buf_control #(.NUM_BUFS(3), .WAIT_CYCLES(3), .MAX_REPEAT(2)) dut_b (
    .clk(clk), .reset(reset), .capture_trigger(cap_b),
    .transmission_trigger(trans_b), .wr_sel(wr_sel_b), .rd_sel(rd_sel_b),
    .wr_switch(wr_switch_b), .rd_switch(rd_switch_b), .frame_drop(frame_drop_b),
    .stale(stale_b), .error(error_b)
  );

  function automatic void chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endfunction

  // Monitor: counts pulses between checkpoints and compares against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      acc_wr = 0; acc_rd = 0; acc_drop = 0;
    end else begin
      acc_wr   += int'(wr_switch);
      acc_rd   += int'(rd_switch);
      acc_drop += int'(frame_drop);
    end
    if (done_cnt != req_cnt) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("queue_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, ".wr_switch"}, acc_wr, e.nw);
        chk({e.name, ".rd_switch"}, acc_rd, e.nr);
        chk({e.name, ".frame_drop"}, acc_drop, e.nd);
        chk({e.name, ".wr_sel"}, int'(wr_sel), e.ws);
        chk({e.name, ".rd_sel"}, int'(rd_sel), e.rs);
        chk({e.name, ".stale"}, int'(stale), e.st);
        chk({e.name, ".error"}, int'(error), 0);
        $display("txn %-10s wr_sw=%0d rd_sw=%0d drop=%0d wr_sel=%0d rd_sel=%0d stale=%0d err=%0d",
                 e.name, acc_wr, acc_rd, acc_drop, wr_sel, rd_sel, stale, error);
      end
      acc_wr = 0; acc_rd = 0; acc_drop = 0;
    end
  end

  task automatic push_exp(input string name, input int nw, nr, nd, ws, rs, st);
    exp_t e;
    e.name = name; e.nw = nw; e.nr = nr; e.nd = nd; e.ws = ws; e.rs = rs; e.st = st;
    exp_q.push_back(e);
  endtask

  task automatic txn(input string name, input logic cap, input logic trn,
                     input int nw, nr, nd, ws, rs, st);
    push_exp(name, nw, nr, nd, ws, rs, st);
    @(negedge clk);
    if (cap) capture_trigger = 1'b1;
    if (trn) transmission_trigger = 1'b0;
    @(negedge clk);
    capture_trigger = 1'b0;
    transmission_trigger = 1'b1;
    repeat (3) @(negedge clk);
    req_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("b_reset.wr_sel", int'(wr_sel_b), 0);
    txn("reset", 0, 0, 0, 0, 0, 0, 1, 0);

    txn("s1_cap", 1, 0, 1, 0, 0, 2, 1, 0);
    txn("s1_trans", 0, 1, 0, 1, 0, 2, 0, 0);
    txn("s1_cap2", 1, 0, 1, 0, 0, 1, 0, 0);

    do_reset();
    txn("s2_cap", 1, 0, 1, 0, 0, 2, 1, 0);
    txn("s2_cap2", 1, 0, 1, 0, 1, 0, 1, 0);
    txn("s2_trans", 0, 1, 0, 1, 0, 0, 2, 0);

    do_reset();
    txn("s3_trans", 0, 1, 0, 0, 0, 0, 1, 0);
    txn("s3_trans2", 0, 1, 0, 0, 0, 0, 1, 1);
    txn("s3_cap", 1, 0, 1, 0, 0, 2, 1, 1);
    txn("s3_trans3", 0, 1, 0, 1, 0, 2, 0, 0);

    do_reset();
    txn("s4_cap", 1, 0, 1, 0, 0, 2, 1, 0);
    txn("s4_both", 1, 1, 1, 1, 1, 0, 2, 0);

    // Reset while the capture qualifier sits in SECOND_WAIT with stale already set.
    do_reset();
    txn("s6_trans", 0, 1, 0, 0, 0, 0, 1, 0);
    txn("s6_trans2", 0, 1, 0, 0, 0, 0, 1, 1);
    push_exp("s6_hold", 1, 0, 0, 2, 1, 1);
    @(negedge clk);
    capture_trigger = 1'b1;
    repeat (4) @(negedge clk);
    req_cnt++;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("s6_async.wr_sel", int'(wr_sel), 0);
    chk("s6_async.rd_sel", int'(rd_sel), 1);
    chk("s6_async.stale", int'(stale), 0);
    chk("s6_async.pulses", int'({wr_switch, rd_switch, frame_drop}), 0);
    chk("s6_async.error", int'(error), 0);
    @(negedge clk);
    capture_trigger = 1'b0;
    reset = 1'b1;
    txn("s6_after", 1, 0, 1, 0, 0, 2, 1, 0);

    // WAIT_CYCLES=3 instance: three active samples are not enough, four are.
    @(negedge clk);
    cap_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 cap_b = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 chk("b_short.wr_switch", int'(wr_switch_b), 0);
    end
    chk("b_short.wr_sel", int'(wr_sel_b), 0);
    @(negedge clk);
    cap_b = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) cap_b = 1'b0;
      if (k == 4) chk("b_e4.wr_switch", int'(wr_switch_b), 0);
      if (k == 5) chk("b_e5.wr_switch", int'(wr_switch_b), 1);
      if (k == 5) chk("b_e5.wr_sel", int'(wr_sel_b), 0);
      if (k == 6) chk("b_e6.wr_sel", int'(wr_sel_b), 2);
      if (k == 6) chk("b_e6.wr_switch", int'(wr_switch_b), 0);
    end
    $display("txn b_wait3   wr_sel=%0d rd_sel=%0d err=%0d", wr_sel_b, rd_sel_b, error_b);

    repeat (3) @(negedge clk);
    chk("queue_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
